// File: rtl/fp_div_issue_queue.sv
// ---------------------------------------------------------------------------
// fp_div_issue_queue
//
// Front end for a single-precision FP divider. Tagged operand pairs arrive on
// a valid/ready port and are buffered in a FIFO. They are issued one at a time
// on div_InputA/div_InputB. After the divider latency, div_AbyB is captured
// into a one-entry output slot and returned on a valid/ready port with the tag.
// The divider's own Exception output is undefined for normal results, so this
// block predecodes exceptions from the operand fields when it pops a pair.
//
// Exception codes: 00 div-by-zero, 01 underflow, 10 overflow, 11 NaN.
//
// Optional feature (macro FP_DIV_EXC_BYPASS_EN):
//   defined     - pairs that predecode as exception or zero dividend go
//                 straight from IDLE to CAPTURE. div_InputA/B keep their old
//                 values for those pairs.
//   not defined - every pair takes the full ISSUE path with the same timing.
//
// Ports:
//   CLOCK, RESET                 rising-edge clock, async active-high reset
//   in_valid/in_ready            operand push handshake (in_ready = !full)
//   in_a, in_b, in_tag           dividend, divisor, user tag
//   div_InputA, div_InputB       registered operands to the divider
//   div_AbyB, div_DONE           divider quotient and done flag
//   out_valid/out_ready          result pop handshake
//   out_result                   quotient, 0 for exceptions and zero dividend
//   out_exception, out_exc_valid predecoded exception code and its qualifier
//   out_tag                      tag of the returned pair
//   busy                         FIFO non-empty, FSM active, or result held
// ---------------------------------------------------------------------------
module fp_div_issue_queue #(
  parameter int DEPTH       = 4,  // power of 2, >= 2
  parameter int TAG_W       = 4,
  parameter int DIV_LATENCY = 1   // >= 1
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      div_InputA,
  output logic [31:0]      div_InputB,
  input  logic [31:0]      div_AbyB,
  input  logic             div_DONE,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [1:0]       out_exception,
  output logic             out_exc_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int WC_W = $clog2(DIV_LATENCY + 2);

  localparam logic [1:0] EXC_DIV0 = 2'b00;
  localparam logic [1:0] EXC_UNF  = 2'b01;
  localparam logic [1:0] EXC_OVF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  typedef enum logic [1:0] {PD_NORMAL, PD_ZERO, PD_EXC} pd_kind_t;

  // ---------------- operand FIFO ----------------
  logic [31:0]      mem_a   [DEPTH];
  logic [31:0]      mem_b   [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, empty, push, pop;
  logic [31:0]      head_a, head_b;
  logic [TAG_W-1:0] head_tag;

  // Extra pointer bit tells full (MSBs differ) from empty (pointers equal).
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head_a   = mem_a[rd_ptr[AW-1:0]];
  assign head_b   = mem_b[rd_ptr[AW-1:0]];
  assign head_tag = mem_tag[rd_ptr[AW-1:0]];

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are live, so stale contents are never observed.
  always_ff @(posedge CLOCK) begin
    if (push) begin
      mem_a[wr_ptr[AW-1:0]]   <= in_a;
      mem_b[wr_ptr[AW-1:0]]   <= in_b;
      mem_tag[wr_ptr[AW-1:0]] <= in_tag;
    end
  end

  // ---------------- predecode of the FIFO head ----------------
  logic [7:0]  ea, eb, diff_ab, diff_ba;
  logic [22:0] ma, mb;
  pd_kind_t    pd_kind;
  logic [1:0]  pd_code;

  assign ea      = head_a[30:23];
  assign eb      = head_b[30:23];
  assign ma      = head_a[22:0];
  assign mb      = head_b[22:0];
  assign diff_ab = ea - eb;  // mod 256 by width
  assign diff_ba = eb - ea;

  // NOTE: every variable written here gets a default first, so no path
  // through the block can leave one unassigned and infer a latch.
  always_comb begin
    pd_kind = PD_NORMAL;
    pd_code = EXC_DIV0;
    if (eb == 8'h00 && mb == '0) begin
      pd_kind = PD_EXC;
      pd_code = EXC_DIV0;
    end else if ((ea == 8'hFF && ma != '0) || (eb == 8'hFF && mb != '0)) begin
      pd_kind = PD_EXC;
      pd_code = EXC_NAN;
    end else if (ea == 8'h00 && ma == '0) begin
      pd_kind = PD_ZERO;
    end else if (diff_ab > 8'd127 && ea > eb) begin
      pd_kind = PD_EXC;
      pd_code = EXC_OVF;
    end else if (diff_ba > 8'd127 && eb > ea) begin
      pd_kind = PD_EXC;
      pd_code = EXC_UNF;
    end
  end

  // ---------------- control FSM ----------------
  state_t           state_q, state_d;
  logic [WC_W-1:0]  wcnt;
  logic             capture, bypass, out_pop;
  logic [TAG_W-1:0] hold_tag;
  pd_kind_t         hold_kind;
  logic [1:0]       hold_code;

  assign out_pop = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    bypass  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The slot must be free by the time this pair is captured.
        if (!empty && (!out_valid || out_ready)) begin
          pop     = 1'b1;
          state_d = ISSUE;
`ifdef FP_DIV_EXC_BYPASS_EN
          // Pairs already resolved by predecode never need the divider.
          if (pd_kind != PD_NORMAL) begin
            bypass  = 1'b1;
            state_d = CAPTURE;
          end
`endif
        end
      end
      // The pop edge is the first of DIV_LATENCY+1 counted edges.
      ISSUE:   if (wcnt == WC_W'(DIV_LATENCY)) state_d = CAPTURE;
      CAPTURE: if (div_DONE) begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      wcnt          <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      div_InputA    <= '0;
      div_InputB    <= '0;
      hold_tag      <= '0;
      hold_kind     <= PD_NORMAL;
      hold_code     <= EXC_DIV0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_exception <= EXC_DIV0;
      out_exc_valid <= 1'b0;
      out_tag       <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;

      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        hold_tag  <= head_tag;
        hold_kind <= pd_kind;
        hold_code <= pd_code;
        wcnt      <= WC_W'(1);
        if (!bypass) begin
          div_InputA <= head_a;
          div_InputB <= head_b;
        end
      end else if (state_q == ISSUE) begin
        wcnt <= wcnt + 1'b1;
      end

      // The slot is always empty when capture fires, so load wins over pop.
      if (capture) begin
        out_valid <= 1'b1;
        out_tag   <= hold_tag;
        unique case (hold_kind)
          PD_NORMAL: begin
            out_result    <= div_AbyB;
            out_exc_valid <= 1'b0;
            out_exception <= EXC_DIV0;
          end
          PD_EXC: begin
            out_result    <= '0;
            out_exc_valid <= 1'b1;
            out_exception <= hold_code;
          end
          default: begin
            out_result    <= '0;
            out_exc_valid <= 1'b0;
            out_exception <= EXC_DIV0;
          end
        endcase
      end else if (out_pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = !empty || (state_q != IDLE) || out_valid;

endmodule

// File: tb/tb_fp_div_issue_queue.sv
`timescale 1ns/1ps
module tb_fp_div_issue_queue;

  localparam int DEPTH       = 4;
  localparam int TAG_W       = 4;
  localparam int DIV_LATENCY = 1;

  logic             CLOCK = 1'b0;
  logic             RESET;
  logic             in_valid, in_ready;
  logic [31:0]      in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      div_InputA, div_InputB;
  logic [31:0]      div_AbyB = '0;
  logic             div_DONE;
  logic             out_valid, out_ready;
  logic [31:0]      out_result;
  logic [1:0]       out_exception;
  logic             out_exc_valid;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  fp_div_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DIV_LATENCY(DIV_LATENCY)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .div_InputA(div_InputA), .div_InputB(div_InputB), .div_AbyB(div_AbyB), .div_DONE(div_DONE),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_exception(out_exception), .out_exc_valid(out_exc_valid), .out_tag(out_tag),
    .busy(busy)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [31:0]      result;
    logic             exc_valid;
    logic [1:0]       exc;
    logic [TAG_W-1:0] tag;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Stand-in divider: arbitrary deterministic quotient, except the known 6/2.
  function automatic logic [31:0] div_stub(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    return (a * 32'h9E3779B1) ^ {b[15:0], b[31:16]} ^ 32'h00C0FFEE;
  endfunction

  // One-edge latency divider model.
  always @(posedge CLOCK) div_AbyB <= div_stub(div_InputA, div_InputB);

  // Reference: the documented predecode rules, in integer arithmetic.
  function automatic resp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [TAG_W-1:0] tag);
    resp_t r;
    int    ea, eb;
    bit    a_zero, b_zero, a_nan, b_nan;
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_zero = (ea == 0) && (a[22:0] == 0);
    b_zero = (eb == 0) && (b[22:0] == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    r      = '0;
    r.tag  = tag;
    if (b_zero)                begin r.exc_valid = 1'b1; r.exc = 2'b00; end
    else if (a_nan || b_nan)   begin r.exc_valid = 1'b1; r.exc = 2'b11; end
    else if (a_zero)           r.result = '0;
    else if (ea - eb >= 128)   begin r.exc_valid = 1'b1; r.exc = 2'b10; end
    else if (eb - ea >= 128)   begin r.exc_valid = 1'b1; r.exc = 2'b01; end
    else                       r.result = div_stub(a, b);
    return r;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  e;
    logic [22:0] m;
    logic        s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 20));
      3:       e = 8'($urandom_range(230, 254));
      default: e = 8'($urandom_range(100, 160));
    endcase
    m = ($urandom_range(0, 2) == 0) ? 23'd0 : 23'($urandom);
    return {s, e, m};
  endfunction

  function automatic resp_t observed();
    return {out_result, out_exc_valid, out_exception, out_tag};
  endfunction

  // Sends one pair into an idle queue and waits for its result.
  // lat = edges from the push edge until out_valid is seen.
  task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, output resp_t got, output int lat);
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b1; div_DONE = 1'b1;
    @(negedge CLOCK);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge CLOCK);
      lat++;
    end
    got = observed();
    @(negedge CLOCK);
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0; div_DONE = 1'b1;
    RESET = 1'b1;
    @(negedge CLOCK);
    n_checks++;
    if ({in_ready, out_valid, busy, out_exc_valid, out_exception, out_tag} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, {TAG_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b exc_valid=%b exc=%b tag=%h, want 1 0 0 0 00 0",
               in_ready, out_valid, busy, out_exc_valid, out_exception, out_tag);
    end
    n_checks++;
    if ({div_InputA, div_InputB, out_result} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data: InputA=%h InputB=%h result=%h, want all 0", div_InputA, div_InputB, out_result);
    end
    RESET = 1'b0;
    @(negedge CLOCK);
  endtask

  task automatic test_latency();
    resp_t got, want;
    int    lat;
    send_one(32'h40C00000, 32'h40000000, 4'd3, got, lat);
    want = '0; want.result = 32'h40400000; want.tag = 4'd3;
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL t1_latency: got %0d edges, want 3", lat);
    end
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL t1_result: got %h, want %h", got, want);
    end
    n_checks++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL t1_idle: out_valid=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  kind;  // 0..3 exception code, 4 zero dividend, 5 normal
  } vec_t;

  task automatic test_exceptions();
    vec_t        vecs[12];
    resp_t       got, want;
    int          lat;
    logic [31:0] prev_a;
    vecs[0]  = '{32'h3F800000, 32'h00000000, 3'd0};
    vecs[1]  = '{32'h7FC00000, 32'h3F800000, 3'd3};
    vecs[2]  = '{32'h7F000000, 32'h00800000, 3'd2};
    vecs[3]  = '{32'h00800000, 32'h7F000000, 3'd1};
    vecs[4]  = '{32'h00000000, 32'h3F800000, 3'd4};
    vecs[5]  = '{32'h00000000, 32'h00000000, 3'd0};
    vecs[6]  = '{32'h7F800001, 32'h00000000, 3'd0};
    vecs[7]  = '{32'h3F800000, 32'hFFC00000, 3'd3};
    vecs[8]  = '{32'h64000000, 32'h24000000, 3'd2};
    vecs[9]  = '{32'h63800000, 32'h24000000, 3'd5};
    vecs[10] = '{32'h24000000, 32'h64000000, 3'd1};
    vecs[11] = '{32'h3FC00000, 32'h40400000, 3'd5};
    for (int i = 0; i < 12; i++) begin
      prev_a = div_InputA;
      send_one(vecs[i].a, vecs[i].b, TAG_W'(i + 2), got, lat);
      want     = '0;
      want.tag = TAG_W'(i + 2);
      if (vecs[i].kind < 3'd4) begin
        want.exc_valid = 1'b1;
        want.exc       = vecs[i].kind[1:0];
      end else if (vecs[i].kind == 3'd5) begin
        want.result = div_stub(vecs[i].a, vecs[i].b);
      end
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL exc_vec%0d: got %h, want %h", i, got, want);
      end
      if (i == 0) begin
        n_checks++;
`ifdef FP_DIV_EXC_BYPASS_EN
        if (lat !== 2 || div_InputA !== prev_a) begin
          n_fail++;
          $display("FAIL t6_bypass: latency %0d InputA %h, want 2 and %h", lat, div_InputA, prev_a);
        end
`else
        if (lat !== 3 || div_InputA !== vecs[0].a) begin
          n_fail++;
          $display("FAIL t6_no_bypass: latency %0d InputA %h, want 3 and %h", lat, div_InputA, vecs[0].a);
        end
`endif
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int          acc, budget;
    resp_t       got, want;
    out_ready = 1'b0; div_DONE = 1'b1; acc = 0;
    for (int i = 0; i < 6; i++) begin
      a = rnd_fp(); b = rnd_fp();
      in_valid = 1'b1; in_a = a; in_b = b; in_tag = TAG_W'(i);
      if (in_ready) begin
        exp_q.push_back(model(a, b, TAG_W'(i)));
        acc++;
      end
      @(negedge CLOCK);
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc !== 5 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_capacity: accepted %0d in_ready=%b, want 5 and 0", acc, in_ready);
    end
    repeat (5) @(negedge CLOCK);
    n_checks++;
    if ({out_valid, out_tag, in_ready} !== {1'b1, {TAG_W{1'b0}}, 1'b0}) begin
      n_fail++;
      $display("FAIL t4_hold: out_valid=%b tag=%h in_ready=%b, want 1 0 0", out_valid, out_tag, in_ready);
    end
    out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 200) begin
      if (out_valid) begin
        want = exp_q.pop_front();
        got  = observed();
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL t4_order: got %h, want %h", got, want);
        end
      end
      @(negedge CLOCK);
      budget++;
    end
    repeat (3) @(negedge CLOCK);
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_drain: %0d results missing busy=%b, want 0 and 0", exp_q.size(), busy);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    resp_t got, want;
    int    lat, seen;
    out_ready = 1'b1; div_DONE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 32'h40000000 + 32'(i) * 32'h00100000; in_b = 32'h3F800000;
      in_tag = TAG_W'(i + 8);
      @(negedge CLOCK);
    end
    in_valid = 1'b0;
    n_checks++;
    if (div_InputA !== 32'h40100000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_pre: InputA=%h busy=%b, want 40100000 and 1", div_InputA, busy);
    end
    RESET = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, out_exc_valid, out_exception, out_tag, div_InputA, div_InputB, out_result}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, {TAG_W{1'b0}}, 96'd0}) begin
      n_fail++;
      $display("FAIL t5_async_reset: in_ready=%b out_valid=%b busy=%b InputA=%h InputB=%h result=%h tag=%h",
               in_ready, out_valid, busy, div_InputA, div_InputB, out_result, out_tag);
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    send_one(32'h41200000, 32'h40A00000, 4'hA, got, lat);
    want = model(32'h41200000, 32'h40A00000, 4'hA);
    n_checks++;
    if (got !== want || lat !== 3) begin
      n_fail++;
      $display("FAIL t5_after: got %h lat %0d, want %h lat 3", got, lat, want);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(negedge CLOCK);
    end
    n_checks++;
    if (seen !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_discard: %0d stale results busy=%b, want 0 and 0", seen, busy);
    end
  endtask

  task automatic test_random();
    resp_t got, want, held;
    bit    hold_pending;
    int    budget;
    logic  rnd_v;
    hold_pending = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rnd_v     = ($urandom_range(0, 9) < 7);
      in_valid  = rnd_v;
      in_a      = rnd_fp();
      in_b      = rnd_fp();
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      div_DONE  = ($urandom_range(0, 9) < 8);
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_tag));
      got = observed();
      if (hold_pending) begin
        n_checks++;
        if (out_valid !== 1'b1 || got !== held) begin
          n_fail++;
          $display("FAIL rnd_stable: valid=%b got %h, want 1 %h", out_valid, got, held);
        end
      end
      hold_pending = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rnd_extra: got %h, want no result", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              n_fail++;
              $display("FAIL rnd_result: got %h, want %h", got, want);
            end
          end
        end else begin
          held = got;
          hold_pending = 1'b1;
        end
      end
      @(negedge CLOCK);
    end
    in_valid = 1'b0; out_ready = 1'b1; div_DONE = 1'b1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 300) begin
      if (out_valid) begin
        want = exp_q.pop_front();
        got  = observed();
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL rnd_drain_result: got %h, want %h", got, want);
        end
      end
      @(negedge CLOCK);
      budget++;
    end
    repeat (3) @(negedge CLOCK);
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rnd_drain: %0d results missing busy=%b, want 0 and 0", exp_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_exceptions();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
